dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller sitting between the RISC-V core's load/store port and the word-addressed data memory. It is the initiator on the data-memory port: it drives word address, write data and write enable, and consumes the memory's combinational read data. Read misses stall the core while a 4-word line is refilled one word per cycle; stores go straight through to memory in one cycle.

## Interface
Parameters:
- ADDR_W, 10, word-address width (matches data-memory depth of 1024 words)
- DATA_W, 32, word width
- INDEX_W, 5, line-index bits (32 lines)
- OFFSET_W, 2, word-in-line bits (4 words/line); TAG_W = ADDR_W-INDEX_W-OFFSET_W = 3

Ports:
- CLK  in  1  single clock, all state updates on rising edge
- RST_n  in  1  asynchronous, active-low reset
- cpu_addr  in  ADDR_W  word address from core
- cpu_wdata  in  DATA_W  store data
- cpu_rd  in  1  load request
- cpu_wr  in  1  store request
- cpu_rdata  out  DATA_W  load data
- stall  out  1  core must hold request and pipeline while high
- mem_addr  out  ADDR_W  data-memory word address
- mem_wdata  out  DATA_W  data-memory write data
- mem_we  out  1  data-memory write enable (memory writes on rising CLK)
- mem_rdata  in  DATA_W  data-memory read data, combinational from mem_addr
- hit_cnt  out  16  read-hit counter
- miss_cnt  out  16  read-miss counter

## Operation
- Address split: tag = cpu_addr[9:7], index = cpu_addr[6:2], offset = cpu_addr[1:0].
- Storage: per line valid bit, 3-bit tag, 4 data words. hit = valid[index] && tag match.
- States: IDLE, REFILL.
- IDLE, cpu_wr=1 (priority over cpu_rd if both high): mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=1, stall=0. On hit, cached word updated at same edge; on miss, cache untouched. Counters unchanged.
- IDLE, cpu_rd=1, hit: cpu_rdata = cached word, stall=0, hit_cnt+1.
- IDLE, cpu_rd=1, miss: stall=1, cpu_rdata=0, latch {tag,index} of cpu_addr, clear valid[index], word counter cnt=0, miss_cnt+1, go REFILL.
- REFILL: stall=1, mem_we=0, mem_addr={latched tag, latched index, cnt}; each edge writes mem_rdata into line word cnt, cnt+1. On edge with cnt=3: store tag, set valid, go IDLE.
- IDLE, no request: stall=0, mem_we=0, mem_addr=cpu_addr, cpu_rdata=0.
- mem_we is never asserted in REFILL; a refill always fetches the whole line starting at offset 0.
- Counters saturate at 0xFFFF.
- Core holds cpu_addr/cpu_rd/cpu_wr stable while stall=1; refill uses latched address regardless.

## Timing
- Reset (RST_n low, asynchronous): state=IDLE, all valid bits 0, cnt=0, hit_cnt=0, miss_cnt=0. Outputs during/after reset with no request: stall=0, mem_we=0, cpu_rdata=0, mem_addr=cpu_addr, mem_wdata=cpu_wdata. Data/tag arrays need no reset.
- Reset asserted mid-REFILL: refill abandoned, partially filled line stays invalid, stall drops immediately.
- Read hit: 0 stall cycles, data valid in request cycle.
- Read miss: detect cycle + 4 REFILL cycles = 5 cycles stall high; request completes as a hit in cycle 6 (hit_cnt also increments then).
- Store: single cycle, no stall; memory and cached word updated at that edge.
- Load following store to same address next cycle returns new data (hit) or refetches new data from memory (miss).
- stall, mem_we, mem_addr, cpu_rdata are combinational from state and inputs; all else registered.

## Test plan
- Reset then cpu_rd at 0x010 with mem[0x010..0x013]=0xA0..0xA3 -> stall high 5 cycles, mem_addr 0x010..0x013 in REFILL, then cpu_rdata=0xA0, miss_cnt=1, hit_cnt=1.
- Follow with reads of 0x011, 0x013 -> 0xA1, 0xA3 with stall=0, hit_cnt=3.
- cpu_wr 0x012 data 0xDEADBEEF (hit) -> mem_we=1 one cycle, mem[0x012] updated, read 0x012 returns 0xDEADBEEF with no stall; write to uncached 0x300 -> memory updated, later read of 0x300 misses.
- Conflict: read 0x090 (same index as 0x010, tag 1) -> miss, refill evicts; read 0x010 -> miss again, miss_cnt increments.
- Drop RST_n in 2nd REFILL cycle -> stall=0 immediately; read same address after release -> full 5-cycle miss, correct data.
- cpu_rd and cpu_wr both high -> treated as store, stall=0, no counter change.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache between the core
// load/store port and a word-addressed data memory with combinational read data.
module dcache_ctrl #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned INDEX_W  = 5,
  parameter int unsigned OFFSET_W = 2
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINE_W  = ADDR_W - OFFSET_W;
  localparam int unsigned SLOT_W  = INDEX_W + OFFSET_W;
  localparam int unsigned LINES   = 1 << INDEX_W;
  localparam int unsigned WORDS   = 1 << SLOT_W;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e              state_q, state_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [15:0]         hit_cnt_q, hit_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [DATA_W-1:0]   data_mem [WORDS];

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [SLOT_W-1:0]   req_slot;
  logic [INDEX_W-1:0]  fill_idx;
  logic                hit;

  logic                data_we;
  logic [SLOT_W-1:0]   data_waddr;
  logic [DATA_W-1:0]   data_wval;
  logic                tag_we;

  assign req_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = cpu_addr[OFFSET_W +: INDEX_W];
  assign req_slot = cpu_addr[SLOT_W-1:0];
  assign fill_idx = line_q[INDEX_W-1:0];
  assign hit      = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  assign mem_wdata = cpu_wdata;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  // Next-state, array write controls and combinational core/memory outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    valid_d    = valid_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    stall      = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = cpu_addr;
    cpu_rdata  = '0;
    data_we    = 1'b0;
    data_waddr = req_slot;
    data_wval  = cpu_wdata;
    tag_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_wr) begin
          mem_we  = 1'b1;
          data_we = hit;
        end else if (cpu_rd) begin
          if (hit) begin
            cpu_rdata = data_mem[req_slot];
            hit_cnt_d = (hit_cnt_q == CNT_MAX) ? hit_cnt_q : hit_cnt_q + 16'd1;
          end else begin
            stall            = 1'b1;
            line_d           = cpu_addr[ADDR_W-1:OFFSET_W];
            valid_d[req_idx] = 1'b0;
            cnt_d            = '0;
            miss_cnt_d       = (miss_cnt_q == CNT_MAX) ? miss_cnt_q : miss_cnt_q + 16'd1;
            state_d          = REFILL;
          end
        end
      end
      REFILL: begin
        // Fetch from the latched line so the refill ignores any address change
        stall      = 1'b1;
        mem_addr   = {line_q, cnt_q};
        data_we    = 1'b1;
        data_waddr = {fill_idx, cnt_q};
        data_wval  = mem_rdata;
        cnt_d      = cnt_q + OFFSET_W'(1);
        if (cnt_q == '1) begin
          tag_we            = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state with asynchronous reset
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      line_q     <= '0;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag and data arrays are qualified by valid bits and need no reset
  always_ff @(posedge CLK) begin
    if (data_we) data_mem[data_waddr] <= data_wval;
    if (tag_we)  tag_mem[fill_idx]    <= line_q[LINE_W-1:INDEX_W];
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized self-checking bench for dcache_ctrl against a line-presence model
// and a reference copy of data memory.
module tb_dcache_ctrl;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  dcache_ctrl dut (
    .CLK(CLK), .RST_n(RST_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 CLK = ~CLK;

  // Environment data memory: combinational read, write on rising edge
  logic [31:0] mem [1024];
  assign mem_rdata = mem[mem_addr];
  always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;

  // Reference model: memory contents plus which tag each line holds
  logic [31:0] ref_mem [1024];
  bit          mv [32];
  logic [2:0]  mt [32];
  int          hit_exp, miss_exp;
  int          checks, errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_hits"}, 32'(hit_cnt), 32'(hit_exp));
    check({tag, "_misses"}, 32'(miss_cnt), 32'(miss_exp));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mv[i] = 1'b0;
    hit_exp  = 0;
    miss_exp = 0;
  endtask

  task automatic do_idle(input logic [9:0] a, input logic [31:0] d);
    @(negedge CLK);
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = a; cpu_wdata = d;
    #1;
    check("idle_stall", 32'(stall), 0);
    check("idle_we", 32'(mem_we), 0);
    check("idle_rdata", cpu_rdata, 0);
    check("idle_addr", 32'(mem_addr), 32'(a));
    check("idle_wdata", mem_wdata, d);
    @(posedge CLK); #1;
    check_counts("idle");
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic also_rd);
    @(negedge CLK);
    cpu_rd = also_rd; cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
    #1;
    check("wr_stall", 32'(stall), 0);
    check("wr_we", 32'(mem_we), 1);
    check("wr_addr", 32'(mem_addr), 32'(a));
    check("wr_wdata", mem_wdata, d);
    @(posedge CLK);
    ref_mem[a] = d;
    #1;
    check("wr_mem", mem[a], d);
    check_counts("wr");
  endtask

  task automatic do_read(input logic [9:0] a);
    logic [4:0] idx;
    logic [2:0] tg;
    idx = a[6:2];
    tg  = a[9:7];
    @(negedge CLK);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = a; cpu_wdata = 32'($urandom);
    #1;
    if (!(mv[idx] && mt[idx] == tg)) begin
      check("miss_stall", 32'(stall), 1);
      check("miss_rdata", cpu_rdata, 0);
      check("miss_we", 32'(mem_we), 0);
      @(posedge CLK);
      miss_exp = sat_inc(miss_exp);
      mv[idx] = 1'b0;
      #1;
      check_counts("miss");
      for (int k = 0; k < 4; k++) begin
        @(negedge CLK); #1;
        check("refill_stall", 32'(stall), 1);
        check("refill_we", 32'(mem_we), 0);
        check("refill_addr", 32'(mem_addr), 32'({a[9:2], 2'(k)}));
        @(posedge CLK);
      end
      mv[idx] = 1'b1;
      mt[idx] = tg;
      @(negedge CLK); #1;
    end
    check("rd_stall", 32'(stall), 0);
    check("rd_data", cpu_rdata, ref_mem[a]);
    @(posedge CLK);
    hit_exp = sat_inc(hit_exp);
    #1;
    check_counts("rd");
  endtask

  // Drop reset during the second refill cycle, then refetch the same line
  task automatic reset_mid_refill(input logic [9:0] a);
    @(negedge CLK);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
    #1;
    check("rst_pre_stall", 32'(stall), 1);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST_n = 1'b0;
    cpu_rd = 1'b0;
    #1;
    model_reset();
    check("rst_stall", 32'(stall), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_addr", 32'(mem_addr), 32'(a));
    check_counts("rst");
    @(negedge CLK);
    RST_n = 1'b1;
    do_read(a);
  endtask

  logic [9:0]  ra;
  logic [31:0] rd_val;
  int          op, n;

  initial begin
    checks = 0; errors = 0;
    RST_n = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 10'h055; cpu_wdata = 32'h1234_5678;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[16 + i] = 32'hA0 + 32'(i);
      ref_mem[16 + i] = mem[16 + i];
    end
    model_reset();

    #12;
    check("reset_stall", 32'(stall), 0);
    check("reset_we", 32'(mem_we), 0);
    check("reset_rdata", cpu_rdata, 0);
    check("reset_addr", 32'(mem_addr), 32'h055);
    check("reset_wdata", mem_wdata, 32'h1234_5678);
    check_counts("reset");
    @(negedge CLK);
    RST_n = 1'b1;

    do_read(10'h010);
    do_read(10'h011);
    do_read(10'h013);
    check("three_hits", 32'(hit_cnt), 3);
    do_write(10'h012, 32'hDEAD_BEEF, 1'b0);
    do_read(10'h012);
    do_write(10'h300, 32'h0BAD_F00D, 1'b0);
    do_idle(10'h300, 32'h0);
    do_read(10'h300);
    do_read(10'h090);
    do_read(10'h010);
    check("conflict_misses", 32'(miss_cnt), 4);
    do_write(10'h011, 32'hCAFE_0011, 1'b1);
    do_read(10'h011);
    reset_mid_refill(10'h234);

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      ra = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      rd_val = $urandom;
      if (op <= 5)      do_read(ra);
      else if (op <= 7) do_write(ra, rd_val, 1'b0);
      else if (op == 8) do_write(ra, rd_val, 1'b1);
      else              do_idle(ra, rd_val);
    end

    // Hold a cached read until the hit counter saturates
    do_read(10'h010);
    @(negedge CLK);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 10'h010;
    n = 65535 - hit_exp + 3;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      hit_exp = sat_inc(hit_exp);
    end
    #1;
    check("sat_hits", 32'(hit_cnt), 32'hFFFF);
    do_read(10'h010);
    check("sat_hold", 32'(hit_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
